// File: rtl/eth_fcs_appender.sv
// Purpose: byte-serial Ethernet FCS stage; forwards frame bytes, zero-pads short frames, appends CRC-32 FCS.
// Latency: one cycle from input accept to registered output presentation.
// Backpressure: m_ready low holds the output register stable and drops s_ready; s_ready is also low during PAD and FCS.
//
// Ports:
//   clk, rst_n                 rising-edge clock, asynchronous active-low reset
//   s_data/s_valid/s_last      input frame byte stream, s_ready accepts it
//   m_data/m_valid/m_last      registered output byte stream, m_last on final FCS byte, m_ready accepts it
//   frame_done                 one-cycle pulse after the final FCS byte is accepted downstream
module eth_fcs_appender #(
    parameter int MIN_FRAME_BYTES = 60,
    parameter int CNT_W           = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready,
    output logic       frame_done
);

    localparam logic [31:0]      CRC_POLY = 32'h04C11DB7;
    localparam logic [31:0]      CRC_INIT = 32'hFFFFFFFF;
    localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_FRAME_BYTES);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, DATA, PAD, FCS} state_t;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] b);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = b[31-i];
        return r;
    endfunction

    // MSB-first shift of 8 bits; callers pass the bit-reversed byte so the
    // Ethernet LSB-first bit order is honoured.
    function automatic logic [31:0] step8(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[31] ^ b[i];
            c  = {c[30:0], 1'b0};
            if (fb) c = c ^ CRC_POLY;
        end
        return c;
    endfunction

    state_t           state, state_nxt;
    logic [31:0]      crc, crc_nxt;
    logic [CNT_W-1:0] count, cnt_nxt, cnt_inc;
    logic [1:0]       fcs_idx, idx_nxt;
    logic [7:0]       data_nxt;
    logic             valid_nxt, last_nxt, done_nxt;
    logic             out_free, s_acc;
    logic [31:0]      fcs;
    logic [7:0]       fcs_byte;

    // Output register can take a new byte when empty or being drained this cycle.
    assign out_free = !m_valid || m_ready;
    assign s_ready  = ((state == IDLE) || (state == DATA)) && out_free;
    assign s_acc    = s_valid && s_ready;

    // Saturating increment: long frames never wrap back below the pad threshold.
    assign cnt_inc  = (count == CNT_MAX) ? count : count + CNT_ONE;

    assign fcs      = ~rev32(crc);
    assign fcs_byte = fcs[{fcs_idx, 3'b000} +: 8];

    always_comb begin
        state_nxt = state;
        data_nxt  = m_data;
        valid_nxt = m_valid && !m_ready;
        last_nxt  = m_valid && m_last && !m_ready;
        crc_nxt   = crc;
        cnt_nxt   = count;
        idx_nxt   = fcs_idx;
        done_nxt  = m_valid && m_ready && m_last;

        case (state)
            IDLE: begin
                if (s_acc) begin
                    data_nxt  = s_data;
                    valid_nxt = 1'b1;
                    last_nxt  = 1'b0;
                    crc_nxt   = step8(CRC_INIT, rev8(s_data));
                    cnt_nxt   = CNT_ONE;
                    idx_nxt   = 2'd0;
                    if (s_last) state_nxt = (CNT_ONE < MIN_CNT) ? PAD : FCS;
                    else        state_nxt = DATA;
                end
            end
            DATA: begin
                if (s_acc) begin
                    data_nxt  = s_data;
                    valid_nxt = 1'b1;
                    last_nxt  = 1'b0;
                    crc_nxt   = step8(crc, rev8(s_data));
                    cnt_nxt   = cnt_inc;
                    idx_nxt   = 2'd0;
                    if (s_last) state_nxt = (cnt_inc < MIN_CNT) ? PAD : FCS;
                end
            end
            PAD: begin
                if (out_free) begin
                    data_nxt  = 8'h00;
                    valid_nxt = 1'b1;
                    last_nxt  = 1'b0;
                    crc_nxt   = step8(crc, 8'h00);
                    cnt_nxt   = cnt_inc;
                    idx_nxt   = 2'd0;
                    if (cnt_inc >= MIN_CNT) state_nxt = FCS;
                end
            end
            FCS: begin
                if (out_free) begin
                    data_nxt  = fcs_byte;
                    valid_nxt = 1'b1;
                    last_nxt  = (fcs_idx == 2'd3);
                    idx_nxt   = fcs_idx + 2'd1;
                    if (fcs_idx == 2'd3) begin
                        state_nxt = IDLE;
                        crc_nxt   = CRC_INIT;
                        cnt_nxt   = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            crc        <= CRC_INIT;
            count      <= '0;
            fcs_idx    <= 2'd0;
            m_data     <= 8'h00;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            crc        <= crc_nxt;
            count      <= cnt_nxt;
            fcs_idx    <= idx_nxt;
            m_data     <= data_nxt;
            m_valid    <= valid_nxt;
            m_last     <= last_nxt;
            frame_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_eth_fcs_appender.sv
// Purpose: directed bench for eth_fcs_appender with a queue scoreboard fed from a reflected CRC-32 model.
// Latency: outputs observed at the falling edge; transfers counted when m_valid && m_ready there.
// Backpressure: m_ready is either held high or randomised per cycle to exercise stalls.
module tb_eth_fcs_appender;

    localparam int MIN = 60;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_data, m_data;
    logic       s_valid, s_last, s_ready, m_valid, m_last, m_ready, frame_done;

    logic [7:0] s_data0, m_data0;
    logic       s_valid0, s_last0, s_ready0, m_valid0, m_last0, m_ready0, frame_done0;

    always #5 clk = ~clk;

    eth_fcs_appender dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .frame_done(frame_done)
    );

    eth_fcs_appender #(.MIN_FRAME_BYTES(0), .CNT_W(11)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data0), .s_valid(s_valid0), .s_last(s_last0), .s_ready(s_ready0),
        .m_data(m_data0), .m_valid(m_valid0), .m_last(m_last0), .m_ready(m_ready0),
        .frame_done(frame_done0)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    bit         exp_last_q[$];
    logic [7:0] got_q[$];
    logic [7:0] got0_q[$];
    int         last0_idx = -1;
    int         done0_cnt = 0;
    int         done0_at  = -1;
    bit         sb_on     = 1'b1;
    bit         rnd_mode  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference FCS: reflected CRC-32 (poly 0xEDB88320), init all-ones, final invert.
    function automatic logic [31:0] crc_ref(input logic [7:0] q[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            c = c ^ {24'h0, q[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Non-reflected register run over a whole frame including FCS; a good frame leaves the magic residue.
    function automatic logic [31:0] residue(input logic [7:0] q[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        logic        fb;
        foreach (q[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[31] ^ q[i][k];
                c  = {c[30:0], 1'b0};
                if (fb) c = c ^ 32'h04C11DB7;
            end
        end
        return c;
    endfunction

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Scoreboard / protocol monitor for the default-parameter instance.
    logic       prev_stall = 1'b0;
    logic [8:0] prev_out   = '0;
    logic       done_exp   = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            done_exp   = 1'b0;
        end else begin
            if (done_exp || frame_done) check("frame_done", 32'(frame_done), 32'(done_exp));
            if (prev_stall) check("stall_hold", {22'h0, m_valid, m_last, m_data}, {22'h0, 1'b1, prev_out});
            if (m_valid && m_ready) begin
                if (sb_on) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", 32'(m_data), 32'hFFFF_FFFF);
                    end else begin
                        check("out_data", 32'(m_data), 32'(exp_q.pop_front()));
                        check("out_last", 32'(m_last), 32'(exp_last_q.pop_front()));
                    end
                end
                got_q.push_back(m_data);
            end
            done_exp   = m_valid && m_ready && m_last;
            prev_stall = m_valid && !m_ready;
            prev_out   = {m_last, m_data};
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid0 && m_ready0) begin
                got0_q.push_back(m_data0);
                if (m_last0) last0_idx = got0_q.size() - 1;
            end
            if (frame_done0) begin
                done0_cnt++;
                done0_at = got0_q.size();
            end
        end
    end

    task automatic wait_accept();
        int k = 0;
        @(negedge clk);
        while (!s_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) begin
            $display("FAIL s_ready_timeout observed=0 required=1");
            $fatal(1, "input handshake timed out");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] fr[$], input bit with_last, input bit push_sb);
        logic [7:0]  full[$];
        logic [31:0] c;
        if (push_sb) begin
            full = fr;
            while (full.size() < MIN) full.push_back(8'h00);
            c = crc_ref(full);
            foreach (full[i]) begin
                exp_q.push_back(full[i]);
                exp_last_q.push_back(1'b0);
            end
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(8'(c >> (8 * b)));
                exp_last_q.push_back(b == 3);
            end
        end
        for (int i = 0; i < fr.size(); i++) begin
            s_valid = 1'b1;
            s_data  = fr[i];
            s_last  = with_last && (i == fr.size() - 1);
            wait_accept();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 5000) begin
            @(posedge clk);
            k++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic make_frame(input int len, input int seed, output logic [7:0] fr[$]);
        fr.delete();
        for (int i = 0; i < len; i++) fr.push_back(8'(i * 37 + seed));
    endtask

    initial begin
        logic [7:0] fr[$];
        logic [7:0] exp0[13];
        int         k;
        int         cnt;

        rst_n = 1'b0;
        s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
        s_valid0 = 1'b0; s_last0 = 1'b0; s_data0 = 8'h00;
        m_ready0 = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // "123456789" through the no-padding instance
        for (int i = 0; i < 9; i++) begin
            s_valid0 = 1'b1;
            s_data0  = 8'h31 + 8'(i);
            s_last0  = (i == 8);
            k = 0;
            @(negedge clk);
            while (!s_ready0 && k < 100) begin
                @(negedge clk);
                k++;
            end
            check("dut0_s_ready", 32'(s_ready0), 32'd1);
            @(posedge clk);
            #1;
        end
        s_valid0 = 1'b0;
        s_last0  = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        exp0 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                 8'h26, 8'h39, 8'hF4, 8'hCB};
        check("dut0_len", 32'(got0_q.size()), 32'd13);
        if (got0_q.size() == 13)
            for (int i = 0; i < 13; i++) check("dut0_byte", {24'h0, got0_q[i]}, {24'h0, exp0[i]});
        check("dut0_last_pos", 32'(last0_idx), 32'd12);
        check("dut0_done_cnt", 32'(done0_cnt), 32'd1);
        check("dut0_done_at", 32'(done0_at), 32'd13);

        // 42-byte ARP frame, padded to 60
        make_frame(42, 5, fr);
        got_q.delete();
        send_frame(fr, 1'b1, 1'b1);
        drain();
        check("arp_len", 32'(got_q.size()), 32'd64);
        check("arp_residue", residue(got_q), 32'hC704DD7B);

        // 70-byte frame: no padding, s_ready low only for the FCS cycles
        make_frame(70, 11, fr);
        got_q.delete();
        send_frame(fr, 1'b1, 1'b1);
        cnt = 0;
        k = 0;
        @(negedge clk);
        while (!s_ready && k < 50) begin
            cnt++;
            k++;
            @(negedge clk);
        end
        check("long_sready_low", 32'(cnt), 32'd4);
        @(posedge clk);
        #1;
        drain();
        check("long_len", 32'(got_q.size()), 32'd74);
        check("long_residue", residue(got_q), 32'hC704DD7B);

        // Three back-to-back frames under random backpressure
        rnd_mode = 1'b1;
        got_q.delete();
        make_frame(5, 23, fr);
        send_frame(fr, 1'b1, 1'b1);
        make_frame(64, 41, fr);
        send_frame(fr, 1'b1, 1'b1);
        make_frame(61, 97, fr);
        send_frame(fr, 1'b1, 1'b1);
        drain();
        rnd_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("b2b_len", 32'(got_q.size()), 32'd197);

        // Single-byte frame
        fr.delete();
        fr.push_back(8'hAA);
        got_q.delete();
        send_frame(fr, 1'b1, 1'b1);
        drain();
        check("single_len", 32'(got_q.size()), 32'd64);
        check("single_residue", residue(got_q), 32'hC704DD7B);

        // Reset asserted mid-frame after byte 20
        sb_on = 1'b0;
        make_frame(30, 3, fr);
        fr = fr[0:19];
        send_frame(fr, 1'b0, 1'b0);
        check("mid_valid_before", 32'(m_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_async_valid", 32'(m_valid), 32'd0);
        check("mid_async_data", 32'(m_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        exp_last_q.delete();
        sb_on = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_valid) cnt++;
        end
        check("mid_no_resume", 32'(cnt), 32'd0);
        @(posedge clk);
        #1;
        make_frame(50, 77, fr);
        got_q.delete();
        send_frame(fr, 1'b1, 1'b1);
        drain();
        check("post_rst_len", 32'(got_q.size()), 32'd64);
        check("post_rst_residue", residue(got_q), 32'hC704DD7B);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
